// File: rtl/acc_pkg.sv
// Shared definitions for the polynomial accumulator.
// Holds the command encodings, the FSM state type and the default
// pipeline constants. The modulus default is the Kyber prime.
package acc_pkg;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_LOAD  = 3'd1;
  localparam logic [2:0] CMD_ACC   = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_CLEAR = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAcc,
    StDrain,
    StClear,
    StRead,
    StDone
  } state_e;

  localparam int unsigned Q_DEFAULT    = 3329;
  localparam int unsigned DRAIN_CYCLES = 2;
  localparam int unsigned SKID_DEPTH   = 2;

endpackage

// File: rtl/dual_ram.sv
// Simple dual-port RAM: port 1 reads, port 2 writes.
// Ports:
//   clk            clock, rising edge
//   en1/addr1      read enable and address; dout1 is registered (1-cycle latency)
//   we2/addr2/din2 write enable, address and data
// A read and write to the same address in one cycle returns the old data.
module dual_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              en1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] dout1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] din2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we2) mem[addr2] <= din2;
    if (en1) dout1 <= mem[addr1];
  end

endmodule

// File: rtl/mod_add_q.sv
// Combinational modular adder: sum = (a + b) mod Q.
// Ports:
//   a    operand already reduced (< Q)
//   b    incoming coefficient, any value < 2Q; reduced once before the add
//   sum  result, < Q
module mod_add_q #(
  parameter int unsigned COEF_W = 12,
  parameter int unsigned Q      = 3329
) (
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [COEF_W-1:0] sum
);

  localparam logic [COEF_W:0] QW = (COEF_W + 1)'(Q);

  logic [COEF_W:0] b_red;
  logic [COEF_W:0] s;

  always_comb begin
    b_red = {1'b0, b};
    if (b_red >= QW) b_red = b_red - QW;
    s = {1'b0, a} + b_red;
    if (s >= QW) s = s - QW;
    sum = s[COEF_W-1:0];
  end

endmodule

// File: rtl/poly_accumulator.sv
// Multi-lane polynomial coefficient accumulator (one dual_ram per lane).
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   cmd                   0 none, 1 load, 2 acc, 3 read, 4 clear
//   status, busy          command in execution (0 when idle) and non-idle flag
//   in_valid/addr/data    input beats for LOAD and ACC, no backpressure
//   out_valid/ready       readout handshake
//   out_addr/data         readout word, held stable while stalled
module poly_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned Q      = Q_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              cmd,
  output logic [2:0]              status,
  output logic                    busy,
  input  logic                    in_valid,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [LANES*COEF_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [LANES*COEF_W-1:0] out_data
);

  localparam int unsigned DATA_W = LANES * COEF_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issued_all_q, issued_all_d;
  logic [1:0]        drain_q, drain_d;

  // ACC pipeline: s1 = accepted beat, s2 = result being written, s3 = last written result
  logic              s1_valid_q, s2_valid_q, s3_valid_q;
  logic [ADDR_W-1:0] s1_addr_q, s2_addr_q, s3_addr_q;
  logic [DATA_W-1:0] s1_data_q, s2_data_q, s3_data_q;

  // Readout: one read in flight plus output register and one skid entry
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d, skid_addr_q, skid_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;

  logic              load_we, clr_we, acc_accept, rd_issue, fire, can_issue;
  logic              use_s2, use_s3;
  logic [1:0]        occupancy;
  logic              ram_rd_en, ram_we;
  logic [ADDR_W-1:0] ram_rd_addr, ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data, ram_rdata, acc_result;
  logic [COEF_W-1:0] lane_rdata [LANES];
  logic [COEF_W-1:0] lane_operand [LANES];
  logic [COEF_W-1:0] lane_sum [LANES];

  assign busy      = (state_q != StIdle);
  assign status    = busy ? mode_q : CMD_NONE;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

  assign fire = out_valid_q & out_ready;
  // Entries leaving this cycle free their slot, which keeps 1 word/cycle streaming.
  assign occupancy = 2'(out_valid_q & ~out_ready) + 2'(skid_valid_q) + 2'(pend_q);
  assign can_issue = (occupancy < 2'(SKID_DEPTH));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    issued_all_d = issued_all_q;
    drain_d      = drain_q;
    load_we      = 1'b0;
    clr_we       = 1'b0;
    acc_accept   = 1'b0;
    rd_issue     = 1'b0;
    unique case (state_q)
      StIdle: begin
        addr_d       = '0;
        issued_all_d = 1'b0;
        drain_d      = '0;
        case (cmd)
          CMD_LOAD:  state_d = StLoad;
          CMD_ACC:   state_d = StAcc;
          CMD_READ:  state_d = StRead;
          CMD_CLEAR: state_d = StClear;
          default:   state_d = StIdle;
        endcase
        if (state_d != StIdle) mode_d = cmd;
      end
      StLoad: begin
        load_we = in_valid;
        if (cmd != CMD_LOAD) state_d = StDrain;
      end
      StAcc: begin
        acc_accept = in_valid;
        if (cmd != CMD_ACC) state_d = StDrain;
      end
      StDrain: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(DRAIN_CYCLES - 1)) state_d = StIdle;
      end
      StClear: begin
        clr_we = 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) state_d = StDone;
      end
      StRead: begin
        if (!issued_all_q && can_issue) begin
          rd_issue = 1'b1;
          addr_d   = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) issued_all_d = 1'b1;
        end
        if (fire && out_addr_q == LAST_ADDR) state_d = StDone;
      end
      StDone: begin
        if (cmd == CMD_NONE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_rd_en   = acc_accept | rd_issue;
    ram_rd_addr = rd_issue ? addr_q : in_addr;
    ram_we      = load_we | clr_we | s2_valid_q;
    ram_wr_addr = s2_addr_q;
    ram_wr_data = s2_data_q;
    if (load_we) begin
      ram_wr_addr = in_addr;
      ram_wr_data = in_data;
    end else if (clr_we) begin
      ram_wr_addr = addr_q;
      ram_wr_data = '0;
    end
  end

  // Results of the two previous beats are not yet visible in the RAM read; newest wins.
  assign use_s2 = s2_valid_q && (s2_addr_q == s1_addr_q);
  assign use_s3 = s3_valid_q && (s3_addr_q == s1_addr_q);

  always_comb begin
    ram_rdata  = '0;
    acc_result = '0;
    for (int l = 0; l < LANES; l++) begin
      ram_rdata[l*COEF_W +: COEF_W]  = lane_rdata[l];
      acc_result[l*COEF_W +: COEF_W] = lane_sum[l];
      if (use_s2)      lane_operand[l] = s2_data_q[l*COEF_W +: COEF_W];
      else if (use_s3) lane_operand[l] = s3_data_q[l*COEF_W +: COEF_W];
      else             lane_operand[l] = lane_rdata[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dual_ram #(
      .DATA_W(COEF_W),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk  (clk),
      .en1  (ram_rd_en),
      .addr1(ram_rd_addr),
      .dout1(lane_rdata[l]),
      .we2  (ram_we),
      .addr2(ram_wr_addr),
      .din2 (ram_wr_data[l*COEF_W +: COEF_W])
    );

    mod_add_q #(
      .COEF_W(COEF_W),
      .Q     (Q)
    ) u_add (
      .a  (lane_operand[l]),
      .b  (s1_data_q[l*COEF_W +: COEF_W]),
      .sum(lane_sum[l])
    );
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || fire) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_addr_d   = skid_addr_q;
        out_data_d   = skid_data_q;
        skid_valid_d = pend_q;
        skid_addr_d  = pend_addr_q;
        skid_data_d  = ram_rdata;
      end else if (pend_q) begin
        out_valid_d = 1'b1;
        out_addr_d  = pend_addr_q;
        out_data_d  = ram_rdata;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (pend_q) begin
      skid_valid_d = 1'b1;
      skid_addr_d  = pend_addr_q;
      skid_data_d  = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      mode_q       <= CMD_NONE;
      addr_q       <= '0;
      issued_all_q <= 1'b0;
      drain_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_data_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_addr_q    <= '0;
      s2_data_q    <= '0;
      s3_valid_q   <= 1'b0;
      s3_addr_q    <= '0;
      s3_data_q    <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      issued_all_q <= issued_all_d;
      drain_q      <= drain_d;
      s1_valid_q   <= acc_accept;
      s1_addr_q    <= in_addr;
      s1_data_q    <= in_data;
      s2_valid_q   <= s1_valid_q;
      s2_addr_q    <= s1_addr_q;
      s2_data_q    <= acc_result;
      s3_valid_q   <= s2_valid_q;
      s3_addr_q    <= s2_addr_q;
      s3_data_q    <= s2_data_q;
      pend_q       <= rd_issue;
      pend_addr_q  <= addr_q;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule
